writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 119 +++++++++++
 tb/tb_writeback_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: arbitrates ALU results and single-outstanding load returns onto one register-file write port
// Ports:
//   clk_i, reset_i (async, active-high)
//   alu_valid_i/alu_rd_i/alu_result_i, alu_stall_o   ALU result in; stall when a load response wins the port
//   ld_req_valid_i/ld_req_ready_o, ld_rd_i/ld_funct3_i/ld_addr_lo_i   load issue (RV32I load types)
//   mem_rsp_valid_i/mem_rsp_data_i                    aligned memory word return
//   wr_en_o/wr_index_o/wr_data_o                      registered register-file write port
//   load_pending_o/pending_rd_o                       outstanding load destination for RAW stalls
//   ld_error_o                                        one-cycle pulse for misaligned/illegal load requests
module writeback_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            alu_stall_o,
  input  logic            ld_req_valid_i,
  output logic            ld_req_ready_o,
  input  logic [4:0]      ld_rd_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_addr_lo_i,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_data_i,
  output logic            wr_en_o,
  output logic [4:0]      wr_index_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic            load_pending_o,
  output logic [4:0]      pending_rd_o,
  output logic            ld_error_o
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t          state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_index_q, wr_index_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic            ld_error_q, ld_error_d;
  logic            illegal, rsp_fire;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  // funct3 3/6/7 are not RV32I loads; halves need even, words zero address bits
  assign illegal = (ld_funct3_i == 3'd3) || (ld_funct3_i[2:1] == 2'b11) ||
                   (ld_funct3_i[1:0] == 2'b01 && ld_addr_lo_i[0]) ||
                   (ld_funct3_i == 3'd2 && ld_addr_lo_i != 2'd0);
  assign rsp_fire = (state_q == WAIT_MEM) && mem_rsp_valid_i;
  assign ld_byte  = mem_rsp_data_i[{lo_q, 3'b000} +: 8];
  assign ld_half  = mem_rsp_data_i[{lo_q[1], 4'b0000} +: 16];
  assign ld_data  = f3_q == 3'd0 ? {{(XLEN-8){ld_byte[7]}}, ld_byte} :
                    f3_q == 3'd4 ? {{(XLEN-8){1'b0}}, ld_byte} :
                    f3_q == 3'd1 ? {{(XLEN-16){ld_half[15]}}, ld_half} :
                    f3_q == 3'd5 ? {{(XLEN-16){1'b0}}, ld_half} : mem_rsp_data_i;
  // the load response owns the write port; the ALU must hold its inputs
  assign alu_stall_o    = rsp_fire && alu_valid_i;
  assign ld_req_ready_o = (state_q == IDLE);
  assign load_pending_o = (state_q == WAIT_MEM);
  assign pending_rd_o   = (state_q == WAIT_MEM) ? rd_q : 5'd0;
  assign wr_en_o        = wr_en_q;
  assign wr_index_o     = wr_index_q;
  assign wr_data_o      = wr_data_q;
  assign ld_error_o     = ld_error_q;
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    f3_d       = f3_q;
    lo_d       = lo_q;
    wr_en_d    = 1'b0;
    wr_index_d = wr_index_q;
    wr_data_d  = wr_data_q;
    ld_error_d = 1'b0;
    if (state_q == IDLE && ld_req_valid_i) begin
      ld_error_d = illegal;
      if (!illegal) begin
        state_d = WAIT_MEM;
        rd_d    = ld_rd_i;
        f3_d    = ld_funct3_i;
        lo_d    = ld_addr_lo_i;
      end
    end
    // x0 destinations leave the write port completely untouched
    if (rsp_fire) begin
      state_d = IDLE;
      if (rd_q != 5'd0) begin
        wr_en_d    = 1'b1;
        wr_index_d = rd_q;
        wr_data_d  = ld_data;
      end
    end else if (alu_valid_i && alu_rd_i != 5'd0) begin
      wr_en_d    = 1'b1;
      wr_index_d = alu_rd_i;
      wr_data_d  = alu_result_i;
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      f3_q       <= '0;
      lo_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_index_q <= '0;
      wr_data_q  <= '0;
      ld_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      f3_q       <= f3_d;
      lo_q       <= lo_d;
      wr_en_q    <= wr_en_d;
      wr_index_q <= wr_index_d;
      wr_data_q  <= wr_data_d;
      ld_error_q <= ld_error_d;
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: randomized self-checking bench for writeback_stage against a behavioural load/write model
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_stall;
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        wr_en;
  logic [4:0]  wr_index;
  logic [31:0] wr_data;
  logic        load_pending;
  logic [4:0]  pending_rd;
  logic        ld_error;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [4:0]  exp_idx;
  logic [31:0] exp_data;

  writeback_stage #(.XLEN(32)) dut (
    .clk_i(clk), .reset_i(rst),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_result_i(alu_result), .alu_stall_o(alu_stall),
    .ld_req_valid_i(ld_req_valid), .ld_req_ready_o(ld_req_ready),
    .ld_rd_i(ld_rd), .ld_funct3_i(ld_funct3), .ld_addr_lo_i(ld_addr_lo),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .wr_en_o(wr_en), .wr_index_o(wr_index), .wr_data_o(wr_data),
    .load_pending_o(load_pending), .pending_rd_o(pending_rd), .ld_error_o(ld_error)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [2:0] f, input logic [1:0] a);
    case (f)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return a == 2'd0 || a == 2'd2;
      3'd2:       return a == 2'd0;
      default:    return 1'b0;
    endcase
  endfunction

  // value loaded from an aligned word: pick size bytes at byte offset a, then extend
  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [1:0] a, input logic [31:0] w);
    int unsigned sz, v, span;
    sz = (f == 3'd2) ? 4 : ((f == 3'd1 || f == 3'd5) ? 2 : 1);
    if (sz == 4) return w;
    span = 1 << (8 * sz);
    v = (w >> (8 * a)) % span;
    if (f < 3'd4 && v >= span / 2) v = v - span;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_req_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet();
    #2;
    n_tests++;
    if ({wr_en, wr_index, wr_data} !== 38'd0) begin
      n_fail++; $display("FAIL reset_wr got en=%0b idx=%0d data=%h exp 0/0/0", wr_en, wr_index, wr_data);
    end
    n_tests++;
    if ({ld_error, load_pending, pending_rd, ld_req_ready} !== 8'b0000_0001) begin
      n_fail++; $display("FAIL reset_ctl got err=%0b pend=%0b prd=%0d rdy=%0b exp 0/0/0/1", ld_error, load_pending, pending_rd, ld_req_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_idx = 0; exp_data = 0;
  endtask

  task automatic test_alu();
    bit v;
    alu_valid = 1; alu_rd = 5; alu_result = 32'hDEADBEEF;
    #1;
    n_tests++;
    if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got=%0b exp=0", alu_stall); end
    tick();
    alu_valid = 0;
    exp_idx = 5; exp_data = 32'hDEADBEEF;
    n_tests++;
    if ({wr_en, wr_index, wr_data} !== {1'b1, exp_idx, exp_data}) begin
      n_fail++; $display("FAIL alu_write got en=%0b idx=%0d data=%h exp 1/%0d/%h", wr_en, wr_index, wr_data, exp_idx, exp_data);
    end
    for (int i = 0; i < 25; i++) begin
      v = 1'($urandom_range(0, 1));
      alu_valid = v;
      alu_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      alu_result = $urandom;
      #1;
      n_tests++;
      if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL alu_rand_stall[%0d] got=%0b exp=0", i, alu_stall); end
      tick();
      if (v && alu_rd != 0) begin exp_idx = alu_rd; exp_data = alu_result; end
      n_tests++;
      if ({wr_en, wr_index, wr_data} !== {v && alu_rd != 0, exp_idx, exp_data}) begin
        n_fail++; $display("FAIL alu_rand[%0d] got en=%0b idx=%0d data=%h exp %0b/%0d/%h", i, wr_en, wr_index, wr_data, v && alu_rd != 0, exp_idx, exp_data);
      end
    end
    quiet();
    tick();
    n_tests++;
    if ({wr_en, wr_index, wr_data} !== {1'b0, exp_idx, exp_data}) begin
      n_fail++; $display("FAIL alu_hold got en=%0b idx=%0d data=%h exp 0/%0d/%h", wr_en, wr_index, wr_data, exp_idx, exp_data);
    end
  endtask

  task automatic test_load_directed();
    logic [2:0]  f3s [3] = '{3'd0, 3'd4, 3'd1};
    logic [31:0] rsps[3] = '{32'h1280_3456, 32'h1280_3456, 32'h8001_0000};
    logic [31:0] exps[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
    for (int i = 0; i < 3; i++) begin
      ld_req_valid = 1; ld_funct3 = f3s[i]; ld_addr_lo = 2; ld_rd = 7;
      #1;
      n_tests++;
      if (ld_req_ready !== 1'b1) begin n_fail++; $display("FAIL ld_dir_ready[%0d] got=%0b exp=1", i, ld_req_ready); end
      tick();
      ld_req_valid = 0;
      n_tests++;
      if ({load_pending, pending_rd, ld_req_ready} !== {1'b1, 5'd7, 1'b0}) begin
        n_fail++; $display("FAIL ld_dir_pend[%0d] got pend=%0b prd=%0d rdy=%0b exp 1/7/0", i, load_pending, pending_rd, ld_req_ready);
      end
      mem_rsp_valid = 1; mem_rsp_data = rsps[i];
      tick();
      mem_rsp_valid = 0;
      exp_idx = 7; exp_data = exps[i];
      n_tests++;
      if ({wr_en, wr_index, wr_data, load_pending} !== {1'b1, exp_idx, exp_data, 1'b0}) begin
        n_fail++; $display("FAIL ld_dir_wr[%0d] got en=%0b idx=%0d data=%h pend=%0b exp 1/%0d/%h/0", i, wr_en, wr_index, wr_data, load_pending, exp_idx, exp_data);
      end
    end
    ld_req_valid = 1; ld_funct3 = 2; ld_addr_lo = 1; ld_rd = 8;
    tick();
    ld_req_valid = 0;
    n_tests++;
    if ({ld_error, wr_en, ld_req_ready, load_pending} !== 4'b1010) begin
      n_fail++; $display("FAIL lw_misalign got err=%0b en=%0b rdy=%0b pend=%0b exp 1/0/1/0", ld_error, wr_en, ld_req_ready, load_pending);
    end
    tick();
    n_tests++;
    if ({ld_error, wr_en} !== 2'b00) begin
      n_fail++; $display("FAIL lw_err_pulse got err=%0b en=%0b exp 0/0", ld_error, wr_en);
    end
  endtask

  task automatic test_load_random();
    logic [2:0]  f;
    logic [1:0]  a;
    logic [4:0]  rd;
    int          dly;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom); a = 2'($urandom); rd = 5'($urandom); dly = $urandom_range(0, 3);
      ld_req_valid = 1; ld_funct3 = f; ld_addr_lo = a; ld_rd = rd;
      tick();
      ld_req_valid = 0;
      if (!legal(f, a)) begin
        n_tests++;
        if ({ld_error, wr_en, load_pending, ld_req_ready} !== 4'b1001) begin
          n_fail++; $display("FAIL ld_rand_illegal[%0d] f3=%0d lo=%0d got err=%0b en=%0b pend=%0b rdy=%0b exp 1/0/0/1", i, f, a, ld_error, wr_en, load_pending, ld_req_ready);
        end
        continue;
      end
      for (int k = 0; k < dly; k++) begin
        ld_req_valid = 1; ld_rd = 5'($urandom);
        n_tests++;
        if ({load_pending, pending_rd, ld_req_ready, ld_error} !== {1'b1, rd, 1'b0, 1'b0}) begin
          n_fail++; $display("FAIL ld_rand_wait[%0d] got pend=%0b prd=%0d rdy=%0b err=%0b exp 1/%0d/0/0", i, load_pending, pending_rd, ld_req_ready, ld_error, rd);
        end
        tick();
        ld_req_valid = 0;
      end
      mem_rsp_valid = 1; mem_rsp_data = $urandom;
      tick();
      mem_rsp_valid = 0;
      if (rd != 0) begin exp_idx = rd; exp_data = ref_load(f, a, mem_rsp_data); end
      n_tests++;
      if ({wr_en, wr_index, wr_data, load_pending} !== {rd != 0, exp_idx, exp_data, 1'b0}) begin
        n_fail++; $display("FAIL ld_rand_wr[%0d] f3=%0d lo=%0d got en=%0b idx=%0d data=%h pend=%0b exp %0b/%0d/%h/0", i, f, a, wr_en, wr_index, wr_data, load_pending, rd != 0, exp_idx, exp_data);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] w;
    w = $urandom;
    ld_req_valid = 1; ld_funct3 = 2; ld_addr_lo = 0; ld_rd = 9;
    tick();
    ld_req_valid = 0;
    mem_rsp_valid = 1; mem_rsp_data = w;
    alu_valid = 1; alu_rd = 3; alu_result = 32'h11;
    #1;
    n_tests++;
    if (alu_stall !== 1'b1) begin n_fail++; $display("FAIL coll_stall got=%0b exp=1", alu_stall); end
    tick();
    mem_rsp_valid = 0;
    n_tests++;
    if ({wr_en, wr_index, wr_data} !== {1'b1, 5'd9, w}) begin
      n_fail++; $display("FAIL coll_load_wr got en=%0b idx=%0d data=%h exp 1/9/%h", wr_en, wr_index, wr_data, w);
    end
    n_tests++;
    if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL coll_unstall got=%0b exp=0", alu_stall); end
    tick();
    alu_valid = 0;
    exp_idx = 3; exp_data = 32'h11;
    n_tests++;
    if ({wr_en, wr_index, wr_data} !== {1'b1, exp_idx, exp_data}) begin
      n_fail++; $display("FAIL coll_alu_wr got en=%0b idx=%0d data=%h exp 1/3/00000011", wr_en, wr_index, wr_data);
    end
  endtask

  task automatic test_idle_rsp();
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_F00D;
    alu_valid = 1; alu_rd = 4; alu_result = 32'h0BAD_0004;
    #1;
    n_tests++;
    if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL idle_rsp_stall got=%0b exp=0", alu_stall); end
    tick();
    quiet();
    exp_idx = 4; exp_data = 32'h0BAD_0004;
    n_tests++;
    if ({wr_en, wr_index, wr_data, load_pending} !== {1'b1, exp_idx, exp_data, 1'b0}) begin
      n_fail++; $display("FAIL idle_rsp_wr got en=%0b idx=%0d data=%h pend=%0b exp 1/4/0bad0004/0", wr_en, wr_index, wr_data, load_pending);
    end
  endtask

  task automatic test_x0();
    alu_valid = 1; alu_rd = 0; alu_result = 32'h5555_AAAA;
    tick();
    alu_valid = 0;
    n_tests++;
    if ({wr_en, wr_index, wr_data} !== {1'b0, exp_idx, exp_data}) begin
      n_fail++; $display("FAIL x0_alu got en=%0b idx=%0d data=%h exp 0/%0d/%h", wr_en, wr_index, wr_data, exp_idx, exp_data);
    end
    ld_req_valid = 1; ld_funct3 = 0; ld_addr_lo = 0; ld_rd = 0;
    tick();
    ld_req_valid = 0;
    n_tests++;
    if ({load_pending, pending_rd} !== {1'b1, 5'd0}) begin
      n_fail++; $display("FAIL x0_pend got pend=%0b prd=%0d exp 1/0", load_pending, pending_rd);
    end
    mem_rsp_valid = 1; mem_rsp_data = 32'h7777_7777;
    tick();
    mem_rsp_valid = 0;
    n_tests++;
    if ({wr_en, wr_index, wr_data, load_pending} !== {1'b0, exp_idx, exp_data, 1'b0}) begin
      n_fail++; $display("FAIL x0_load got en=%0b idx=%0d data=%h pend=%0b exp 0/%0d/%h/0", wr_en, wr_index, wr_data, load_pending, exp_idx, exp_data);
    end
  endtask

  task automatic test_reset_wait();
    ld_req_valid = 1; ld_funct3 = 2; ld_addr_lo = 0; ld_rd = 12;
    tick();
    ld_req_valid = 0;
    n_tests++;
    if ({load_pending, pending_rd} !== {1'b1, 5'd12}) begin
      n_fail++; $display("FAIL rstw_pend got pend=%0b prd=%0d exp 1/12", load_pending, pending_rd);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({load_pending, pending_rd, ld_req_ready, wr_en, wr_index, wr_data} !== {1'b1 ^ 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0}) begin
      n_fail++; $display("FAIL rstw_async got pend=%0b prd=%0d rdy=%0b en=%0b idx=%0d data=%h exp 0/0/1/0/0/0", load_pending, pending_rd, ld_req_ready, wr_en, wr_index, wr_data);
    end
    tick();
    rst = 1'b0;
    exp_idx = 0; exp_data = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'h1234_5678;
    tick();
    mem_rsp_valid = 0;
    n_tests++;
    if ({wr_en, wr_index, wr_data, load_pending, ld_req_ready} !== {1'b0, exp_idx, exp_data, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rstw_rsp got en=%0b idx=%0d data=%h pend=%0b rdy=%0b exp 0/0/0/0/1", wr_en, wr_index, wr_data, load_pending, ld_req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_directed();
    test_load_random();
    test_collision();
    test_idle_rsp();
    test_x0();
    test_reset_wait();
    test_alu();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
